ram_block_copy: RTL and testbench
=================================

// Module: ram_block_copy
// PURPOSE
//  Initiator-side engine for the team's synchronous dual-port RAM (1-cycle registered read).
//  On start, it copies len words from src_addr upward to dst_addr upward.
//  Port A reads the source words; port B writes the destination words.
//  Reads and writes are pipelined: one word per cycle in steady state.
//  Used for buffer relocation and initialisation between RAM regions.
// PARAMETERS
//  A_WIDTH  3  RAM address width; RAM depth = 2**A_WIDTH
//  D_WIDTH  8  RAM data width
// PORTS
//  clk         in   1          rising-edge clock
//  rst_n       in   1          asynchronous active-low reset
//  start       in   1          request a copy; sampled only in IDLE
//  src_addr    in   A_WIDTH    first source address
//  dst_addr    in   A_WIDTH    first destination address
//  len         in   A_WIDTH+1  word count, 0..2**A_WIDTH
//  busy        out  1          copy in progress
//  done        out  1          one-cycle pulse when the copy completes
//  ram_we_a    out  1          port A write enable; constant 0
//  ram_add_a   out  A_WIDTH    port A (read) address
//  ram_din_a   out  D_WIDTH    constant 0
//  ram_dout_a  in   D_WIDTH    port A registered read data
//  ram_we_b    out  1          port B write enable
//  ram_add_b   out  A_WIDTH    port B (write) address
//  ram_din_b   out  D_WIDTH    port B write data = ram_dout_a (combinational)
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - State = IDLE; busy, done, ram_we_b, ram_add_a and ram_add_b are all 0.
//  Register rules:
//   - All outputs are registered except ram_din_b.
//   - At an accepted start, src_addr, dst_addr and len are latched.
//   - len > 2**A_WIDTH saturates to 2**A_WIDTH.
//  States: IDLE, RUN, DRAIN.
//  IDLE:
//   - start=1 with len=0: stay in IDLE; done=1 for the next cycle; no RAM access.
//   - start=1 with len>0: go to RUN; busy=1; ram_add_a=src; ram_we_b=0.
//  RUN, after edge k (k=1..len-1):
//   - ram_add_a = src+k
//   - ram_we_b = 1, ram_add_b = dst+k-1
//   - After edge len-1, go to DRAIN.
//  DRAIN, after edge len:
//   - ram_we_b = 1, ram_add_b = dst+len-1 (final write).
//   - Next state is IDLE.
//  Completion:
//   - After edge len+1: busy=0, done=1 for exactly one cycle, ram_we_b=0.
//   - busy is high for len+1 cycles; writes occur on len consecutive cycles.
//  Address arithmetic:
//   - Addresses wrap modulo 2**A_WIDTH (src+k and dst+k are truncated).
//  Overlap rules:
//   - The copy proceeds in ascending order.
//   - A source word read on the same edge as a write to that address returns the old
//     value, because the RAM is read-first across ports.
//   - dst==src rewrites identical data.
//  start while busy: ignored, with no queueing.
//  Reset mid-copy:
//   - Aborts immediately and all outputs go to reset values.
//   - Words already written stay written; there is no done pulse.
// TESTING
//  1. Preload RAM[0..3]=11,22,33,44; start src=0 dst=4 len=4.
//     -> RAM[4..7]=11,22,33,44; busy high 5 cycles; done 1 pulse.
//  2. Wrap: preload RAM[6]=A6, RAM[7]=A7; src=6 dst=0 len=2.
//     -> RAM[0]=A6, RAM[1]=A7; ram_add_a sequence 6,7.
//  3. len=0 start.
//     -> done pulses the next cycle; busy stays 0; ram_we_b never asserted.
//  4. Pulse start (src=1) while busy.
//     -> ignored; the first copy completes unchanged; exactly one done pulse.
//  5. Assert rst_n=0 after the 2nd write of a len=8 copy.
//     -> outputs 0 immediately; only 2 dst words changed; no done pulse.
//  6. len=15 (A_WIDTH=3).
//     -> saturates to 8 words; busy high 9 cycles.

Source files
------------

// File: rtl/ram_block_copy.sv
// Copies len words from src_addr to dst_addr through a read-first dual-port RAM, one word per cycle.
// busy covers len+1 cycles; a start seen while busy is dropped, never queued.
module ram_block_copy #(
    parameter int A_WIDTH = 3,
    parameter int D_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [A_WIDTH-1:0] src_addr,
    input  logic [A_WIDTH-1:0] dst_addr,
    input  logic [A_WIDTH:0]   len,
    output logic               busy,
    output logic               done,
    output logic               ram_we_a,
    output logic [A_WIDTH-1:0] ram_add_a,
    output logic [D_WIDTH-1:0] ram_din_a,
    input  logic [D_WIDTH-1:0] ram_dout_a,
    output logic               ram_we_b,
    output logic [A_WIDTH-1:0] ram_add_b,
    output logic [D_WIDTH-1:0] ram_din_b
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam int             DEPTH_I = 1 << A_WIDTH;
    localparam logic [A_WIDTH:0] DEPTH = DEPTH_I[A_WIDTH:0];

    logic [1:0]         state;
    logic [A_WIDTH-1:0] src_q;
    logic [A_WIDTH-1:0] dst_q;
    logic [A_WIDTH:0]   len_q;
    logic [A_WIDTH:0]   k;
    logic [A_WIDTH:0]   k_nxt;

    assign k_nxt     = k + {{A_WIDTH{1'b0}}, 1'b1};
    assign ram_we_a  = 1'b0;
    assign ram_din_a = '0;
    // Read data from port A lands one cycle after its address; it goes straight to port B.
    assign ram_din_b = ram_dout_a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            k         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ram_we_b  <= 1'b0;
            ram_add_a <= '0;
            ram_add_b <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len == '0) begin
                            done <= 1'b1;
                        end else begin
                            src_q     <= src_addr;
                            dst_q     <= dst_addr;
                            len_q     <= (len > DEPTH) ? DEPTH : len;
                            k         <= '0;
                            ram_add_a <= src_addr;
                            ram_we_b  <= 1'b0;
                            busy      <= 1'b1;
                            state     <= RUN;
                        end
                    end
                end
                RUN: begin
                    // Write lags read by one word; the last write happens while in DRAIN.
                    k         <= k_nxt;
                    ram_we_b  <= 1'b1;
                    ram_add_b <= dst_q + k[A_WIDTH-1:0];
                    if (k_nxt == len_q) begin
                        state <= DRAIN;
                    end else begin
                        ram_add_a <= src_q + k_nxt[A_WIDTH-1:0];
                    end
                end
                DRAIN: begin
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    ram_we_b <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_block_copy.sv
// Bench for ram_block_copy: read-first RAM model, vector table, random copies vs a word-level reference.
module tb_ram_block_copy;

    typedef logic [7:0] img_t [8];

    typedef struct {
        int s;
        int d;
        int l;
        int exp_busy;
        int exp_wr;
        int exp_done;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] src_addr = '0;
    logic [2:0] dst_addr = '0;
    logic [3:0] len = '0;
    logic       busy, done, ram_we_a, ram_we_b;
    logic [2:0] ram_add_a, ram_add_b;
    logic [7:0] ram_din_a, ram_din_b;
    logic [7:0] ram_dout_a;

    img_t mem;
    img_t pl_img;
    logic pl_go = 1'b0;
    logic [2:0] aseq [$];

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    ram_block_copy #(.A_WIDTH(3), .D_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .busy(busy), .done(done),
        .ram_we_a(ram_we_a), .ram_add_a(ram_add_a), .ram_din_a(ram_din_a), .ram_dout_a(ram_dout_a),
        .ram_we_b(ram_we_b), .ram_add_b(ram_add_b), .ram_din_b(ram_din_b)
    );

    // Read-first dual-port RAM with registered read
    always @(posedge clk) begin
        if (pl_go) mem <= pl_img;
        else if (ram_we_b) mem[ram_add_b] <= ram_din_b;
        ram_dout_a <= mem[ram_add_a];
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic chk_mem(input string name, input img_t exp);
        int bad = -1;
        for (int i = 0; i < 8; i++) if (mem[i] !== exp[i] && bad < 0) bad = i;
        n_tot++;
        if (bad < 0) n_pass++;
        else $display("FAIL %s: mem[%0d] got %0h expected %0h", name, bad, mem[bad], exp[bad]);
    endtask

    task automatic preload(input img_t img);
        @(negedge clk);
        pl_img = img;
        pl_go  = 1'b1;
        @(negedge clk);
        pl_go  = 1'b0;
    endtask

    // Word-level reference: step t reads word t-1 (old contents) then writes word t-2.
    task automatic ref_copy(input img_t m_in, input int s, input int d, input int l, output img_t m_out);
        img_t m;
        logic [7:0] v [$];
        logic [7:0] rd;
        int n;
        m = m_in;
        n = (l > 8) ? 8 : l;
        for (int t = 1; t <= n + 1; t++) begin
            rd = m[(s + t - 1) % 8];
            if (t >= 2) m[(d + t - 2) % 8] = v[t - 2];
            if (t - 1 < n) v.push_back(rd);
        end
        m_out = m;
    endtask

    task automatic do_copy(input int s, input int d, input int l, input bit mid,
                           output int bc, output int wc, output int dc);
        int n;
        n = (l > 8) ? 8 : l;
        bc = 0; wc = 0; dc = 0;
        aseq.delete();
        @(negedge clk);
        start = 1'b1; src_addr = 3'(s); dst_addr = 3'(d); len = 4'(l);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 0) start = 1'b0;
            if (mid && c == 2) begin start = 1'b1; src_addr = 3'd1; end
            if (mid && c == 3) start = 1'b0;
            if (busy) bc++;
            if (ram_we_b) wc++;
            if (done) dc++;
            if (busy && aseq.size() < n) aseq.push_back(ram_add_a);
        end
    endtask

    task automatic run_vec(input string name, input img_t img, input int s, input int d, input int l,
                           input bit mid, input int eb, input int ew, input int ed);
        img_t exp;
        int bc, wc, dc;
        preload(img);
        ref_copy(img, s, d, l, exp);
        do_copy(s, d, l, mid, bc, wc, dc);
        chk({name, " busy cycles"}, bc, eb);
        chk({name, " write cycles"}, wc, ew);
        chk({name, " done pulses"}, dc, ed);
        chk_mem({name, " ram"}, exp);
    endtask

    task automatic rand_img(output img_t img);
        for (int i = 0; i < 8; i++) img[i] = 8'($urandom);
    endtask

    initial begin
        vec_t vecs [6];
        img_t img, exp;
        int bc, wc, dc, n;

        vecs[0] = '{s: 0, d: 4, l: 4,  exp_busy: 5, exp_wr: 4, exp_done: 1};
        vecs[1] = '{s: 6, d: 0, l: 2,  exp_busy: 3, exp_wr: 2, exp_done: 1};
        vecs[2] = '{s: 3, d: 5, l: 0,  exp_busy: 0, exp_wr: 0, exp_done: 1};
        vecs[3] = '{s: 2, d: 3, l: 15, exp_busy: 9, exp_wr: 8, exp_done: 1};
        vecs[4] = '{s: 5, d: 5, l: 8,  exp_busy: 9, exp_wr: 8, exp_done: 1};
        vecs[5] = '{s: 0, d: 1, l: 5,  exp_busy: 6, exp_wr: 5, exp_done: 1};

        repeat (3) @(negedge clk);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset we_b", int'(ram_we_b), 0);
        chk("reset add_a", int'(ram_add_a), 0);
        chk("reset add_b", int'(ram_add_b), 0);
        chk("we_a const", int'(ram_we_a), 0);
        chk("din_a const", int'(ram_din_a), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic copy with explicit values
        img = '{8'd11, 8'd22, 8'd33, 8'd44, 8'd0, 8'd0, 8'd0, 8'd0};
        preload(img);
        do_copy(0, 4, 4, 1'b0, bc, wc, dc);
        chk("t1 ram4", int'(mem[4]), 11);
        chk("t1 ram5", int'(mem[5]), 22);
        chk("t1 ram6", int'(mem[6]), 33);
        chk("t1 ram7", int'(mem[7]), 44);
        chk("t1 busy", bc, 5);
        chk("t1 done", dc, 1);

        // Wrap-around and read address sequence
        img = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hA6, 8'hA7};
        preload(img);
        do_copy(6, 0, 2, 1'b0, bc, wc, dc);
        chk("t2 ram0", int'(mem[0]), 8'hA6);
        chk("t2 ram1", int'(mem[1]), 8'hA7);
        chk("t2 add_a count", aseq.size(), 2);
        if (aseq.size() == 2) begin
            chk("t2 add_a[0]", int'(aseq[0]), 6);
            chk("t2 add_a[1]", int'(aseq[1]), 7);
        end

        for (int i = 0; i < 6; i++) begin
            rand_img(img);
            run_vec($sformatf("vec%0d", i), img, vecs[i].s, vecs[i].d, vecs[i].l, 1'b0,
                    vecs[i].exp_busy, vecs[i].exp_wr, vecs[i].exp_done);
        end

        // Start pulse while busy is dropped
        rand_img(img);
        run_vec("start while busy", img, 4, 0, 4, 1'b1, 5, 4, 1);

        // Reset after the second write of an 8-word copy
        rand_img(img);
        preload(img);
        @(negedge clk);
        start = 1'b1; src_addr = 3'd4; dst_addr = 3'd0; len = 4'd8;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort busy", int'(busy), 0);
        chk("abort we_b", int'(ram_we_b), 0);
        chk("abort add_a", int'(ram_add_a), 0);
        chk("abort add_b", int'(ram_add_b), 0);
        chk("abort done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        dc = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) dc++;
        end
        chk("abort no done", dc, 0);
        exp = img;
        exp[0] = img[4];
        exp[1] = img[5];
        chk_mem("abort ram", exp);

        // Random copies against the reference
        for (int i = 0; i < 16; i++) begin
            int s, d, l;
            s = $urandom_range(0, 7);
            d = $urandom_range(0, 7);
            l = $urandom_range(0, 15);
            n = (l > 8) ? 8 : l;
            rand_img(img);
            run_vec($sformatf("rand%0d", i), img, s, d, l, 1'b0, (n == 0) ? 0 : n + 1, n, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
